// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and ALU: opcodes, FSM states and
// instruction-word field positions.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LDI  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam logic [3:0] ALU_NA  = 4'd15;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: register-file read addresses, immediate
// and instruction class flags from the instruction register.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  op,
    output logic [3:0]  rd,
    output logic [3:0]  off4,
    output logic [7:0]  imm8,
    output logic [3:0]  raddr_a,
    output logic [3:0]  raddr_b,
    output logic        use_imm,
    output logic        is_branch,
    output logic        writes_rf,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] rs1;
    logic [3:0] rs2;

    always_comb begin
        op         = ir[OP_MSB:OP_LSB];
        rd         = ir[RD_MSB:RD_LSB];
        rs1        = ir[RS1_MSB:RS1_LSB];
        rs2        = ir[RS2_MSB:RS2_LSB];
        off4       = rs2;
        imm8       = ir[IMM_MSB:IMM_LSB];
        raddr_a    = rs1;
        raddr_b    = rs2;
        use_imm    = 1'b0;
        is_branch  = 1'b0;
        writes_rf  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: writes_rf = 1'b1;
            OP_LDI: begin
                use_imm   = 1'b1;
                writes_rf = 1'b1;
            end
            // branches compare rd against rs1; the field at [3:0] is the offset
            OP_BNE, OP_BEQ: begin
                raddr_a   = rd;
                raddr_b   = rs1;
                is_branch = 1'b1;
            end
            OP_MOV: begin
                raddr_b   = rs1;
                writes_rf = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller driving the 8-bit ALU,
// the instruction fetch port and the register file.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     DATA_W   = 8,
    parameter int unsigned     RF_AW    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [RF_AW-1:0]  rf_raddr_a,
    output logic [RF_AW-1:0]  rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [3:0]        alu_func,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [15:0]     ir;
    logic [3:0]      flags_q;

    logic [3:0] op, rd, off4, dec_raddr_a, dec_raddr_b;
    logic [7:0] imm8;
    logic       use_imm, is_branch, writes_rf, is_halt, is_illegal;
    logic       start_ok;
    logic       unused_flags;

    cpu_decode u_decode (
        .ir         (ir),
        .op         (op),
        .rd         (rd),
        .off4       (off4),
        .imm8       (imm8),
        .raddr_a    (dec_raddr_a),
        .raddr_b    (dec_raddr_b),
        .use_imm    (use_imm),
        .is_branch  (is_branch),
        .writes_rf  (writes_rf),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign rf_raddr_a   = dec_raddr_a;
    assign rf_raddr_b   = dec_raddr_b;
    assign start_ok     = start && (state == ST_IDLE || state == ST_HALT);
    assign unused_flags = ^flags_q[3:1];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start_ok) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = RESET_PC;
                end
            end
            ST_FETCH:  if (imem_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = is_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB: begin
                state_nxt = ST_FETCH;
                // flag bit0 low means the ALU found the branch condition true
                if (is_branch && !flags_q[0])
                    pc_nxt = pc + {{(PC_W-4){off4[3]}}, off4};
                else
                    pc_nxt = pc + PC_W'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            flags_q    <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            alu_func   <= ALU_NA;
            alu_a      <= '0;
            alu_b      <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            imem_req <= (state_nxt == ST_FETCH);
            busy     <= (state_nxt == ST_FETCH) || (state_nxt == ST_DECODE) ||
                        (state_nxt == ST_EXEC)  || (state_nxt == ST_WB);
            halted   <= (state_nxt == ST_HALT);
            if (state_nxt == ST_FETCH)
                imem_addr <= pc_nxt;
            if (state == ST_FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == ST_DECODE) begin
                alu_a <= rf_rdata_a;
                alu_b <= use_imm ? DATA_W'(imm8) : rf_rdata_b;
            end
            alu_func <= (state_nxt == ST_EXEC && !is_illegal) ? op : ALU_NA;
            if (state == ST_EXEC) begin
                flags_q  <= alu_flags;
                rf_wdata <= alu_result;
                rf_waddr <= RF_AW'(rd);
            end
            rf_we <= (state == ST_EXEC) && writes_rf;
            if (start_ok)
                illegal_op <= 1'b0;
            else if (state == ST_DECODE && is_illegal)
                illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a behavioural instruction memory, register
// file and ALU around it.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [7:0]  rf_rdata_a, rf_rdata_b;
    logic [3:0]  alu_func;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_flags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        busy, halted, illegal_op;

    cpu_ctrl #(.PC_W(8), .DATA_W(8), .RF_AW(4), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [7:0]  d;
        int unsigned c;
    } wr_t;

    logic [15:0] mem [256];
    logic [7:0]  rf [16];
    logic        pl_en;
    logic [3:0]  pl_a;
    logic [7:0]  pl_d;
    int unsigned cyc;
    int unsigned ack_delay;
    int unsigned wcnt;
    logic [7:0]  first_addr;
    logic [7:0]  fa [$];
    int unsigned reqlen [$];
    wr_t         wl [$];
    int unsigned addr_unstable;
    int unsigned rf_during_fetch;
    int          n_tests;
    int          n_fail;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en)
            rf[pl_a] <= pl_d;
        else if (rf_we)
            rf[rf_waddr] <= rf_wdata;
    end

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    // Reference ALU: branch ops clear flag bit0 when their condition holds
    always_comb begin
        alu_result = '0;
        alu_flags  = 4'b0001;
        case (alu_func)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a * alu_b;
            4'd3: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            4'd4: alu_result = alu_b;
            4'd5: alu_flags  = {3'b000, (alu_a != alu_b) ? 1'b0 : 1'b1};
            4'd6: alu_flags  = {3'b000, (alu_a == alu_b) ? 1'b0 : 1'b1};
            4'd7: alu_result = alu_b;
            default: alu_result = '0;
        endcase
    end

    // Instruction memory with programmable ack latency, plus bus logging
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt == 0) first_addr = imem_addr;
            if (rf_we) rf_during_fetch++;
            if (wcnt == ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                fa.push_back(imem_addr);
                reqlen.push_back(wcnt + 1);
                if (imem_addr != first_addr) addr_unstable++;
            end else begin
                imem_ack = 1'b0;
            end
            wcnt++;
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
        if (rf_we) wl.push_back('{a: rf_waddr, d: rf_wdata, c: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk); pl_en = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halt"}, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bw, bf, s, n, ru, rd0;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; ack_delay = 0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_halted",   {31'd0, halted},     32'd0);
        check("rst_req",      {31'd0, imem_req},   32'd0);
        check("rst_func",     {28'd0, alu_func},   32'hF);
        check("rst_we",       {31'd0, rf_we},      32'd0);
        check("rst_illegal",  {31'd0, illegal_op}, 32'd0);
        check("rst_addr",     {24'd0, imem_addr},  32'd0);

        // LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT with zero-wait fetch
        mem[0] = 16'h4105; mem[1] = 16'h4203; mem[2] = 16'h0312; mem[3] = 16'hF000;
        bw = wl.size(); bf = fa.size();
        pulse_start();
        s = cyc;
        wait_halt("prog_a", 100);
        check("a_nwrites", wl.size() - bw, 3);
        check("a_w0_addr", {28'd0, wl[bw].a}, 32'd1);
        check("a_w0_data", {24'd0, wl[bw].d}, 32'd5);
        check("a_w0_cyc",  wl[bw].c - s, 3);
        check("a_w2_addr", {28'd0, wl[bw+2].a}, 32'd3);
        check("a_w2_data", {24'd0, wl[bw+2].d}, 32'd8);
        check("a_w2_cyc",  wl[bw+2].c - s, 11);
        check("a_nfetch",  fa.size() - bf, 4);
        check("a_busy",    {31'd0, busy}, 32'd0);
        check("a_rf3",     {24'd0, rf[3]}, 32'd8);

        // Same program with three wait cycles on every fetch
        ack_delay = 3;
        bw = wl.size(); bf = fa.size(); ru = addr_unstable; rd0 = rf_during_fetch;
        pulse_start();
        s = cyc;
        wait_halt("delay", 200);
        check("d_reqlen0",   reqlen[bf], 4);
        check("d_reqlen3",   reqlen[bf+3], 4);
        check("d_addr_stbl", addr_unstable - ru, 0);
        check("d_rf_quiet",  rf_during_fetch - rd0, 0);
        check("d_w2_cyc",    wl[bw+2].c - s, 20);
        check("d_w2_data",   {24'd0, wl[bw+2].d}, 32'd8);
        ack_delay = 0;

        // SUB r0,r0,r0 with r0=0x80; start pulses while busy must be ignored
        set_reg(4'd0, 8'h80);
        mem[0] = 16'h1000; mem[1] = 16'hF000;
        bw = wl.size(); bf = fa.size();
        pulse_start();
        repeat (3) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        wait_halt("sub", 100);
        check("s_nwrites", wl.size() - bw, 1);
        check("s_w_addr",  {28'd0, wl[bw].a}, 32'd0);
        check("s_w_data",  {24'd0, wl[bw].d}, 32'd0);
        check("s_nfetch",  fa.size() - bf, 2);
        check("s_fetch1",  {24'd0, fa[bf+1]}, 32'd1);

        // BEQ taken back to 2, then the same slot rewritten as BNE (not taken)
        mem[0] = 16'h4107; mem[1] = 16'h4207; mem[2] = 16'h7310;
        mem[3] = 16'h7420; mem[4] = 16'h612E; mem[5] = 16'hF000;
        bf = fa.size();
        pulse_start();
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            if (fa.size() - bf >= 5) mem[4] = 16'h512E;
            n++;
        end
        check("br_halt",   {31'd0, halted}, 32'd1);
        check("br_nfetch", fa.size() - bf, 9);
        check("beq_tgt",   {24'd0, fa[bf+5]}, 32'd2);
        check("bne_fall",  {24'd0, fa[bf+8]}, 32'd5);

        // PC wrap both ways: 2-3 -> 0xFF, then BNE +1 at 0xFF -> 0x00
        mem[0] = 16'h4101; mem[1] = 16'h4202; mem[2] = 16'h512D; mem[8'hFF] = 16'h5121;
        bf = fa.size();
        pulse_start();
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            if (fa.size() - bf >= 1) mem[0] = 16'hF000;
            n++;
        end
        check("wr_halt",   {31'd0, halted}, 32'd1);
        check("wr_nfetch", fa.size() - bf, 5);
        check("wr_ff",     {24'd0, fa[bf+3]}, 32'hFF);
        check("wr_zero",   {24'd0, fa[bf+4]}, 32'h00);

        // Opcode 9 at 0x10 is a NOP that sets the sticky flag
        for (int i = 0; i < 16; i++) mem[i] = 16'h7660;
        mem[16] = 16'h9000; mem[17] = 16'hF000;
        bw = wl.size(); bf = fa.size();
        pulse_start();
        wait_halt("illegal", 400);
        check("il_flag",    {31'd0, illegal_op}, 32'd1);
        check("il_nwrites", wl.size() - bw, 16);
        check("il_f10",     {24'd0, fa[bf+16]}, 32'h10);
        check("il_f11",     {24'd0, fa[bf+17]}, 32'h11);

        // Restart clears the flag; reset during the stalled fetch drops req at once
        ack_delay = 50;
        pulse_start();
        check("il_clear",   {31'd0, illegal_op}, 32'd0);
        check("rs_req_on",  {31'd0, imem_req},   32'd1);
        check("rs_addr",    {24'd0, imem_addr},  32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rs_req_off", {31'd0, imem_req}, 32'd0);
        check("rs_busy",    {31'd0, busy},     32'd0);
        @(negedge clk);
        ack_delay = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_idle_req", {31'd0, imem_req}, 32'd0);
        check("rs_idle_hlt", {31'd0, halted},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
